// File: rtl/wishbone_bus_if_pkg.sv
// Shared definitions for the OpenMIPS Wishbone bridge: bus constants, FSM encoding
// and the registered bus-request record.
package wishbone_bus_if_pkg;

    localparam int          RegBus      = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        ChipEnable  = 1'b1;

    typedef enum logic [1:0] {
        WB_IDLE           = 2'b00,
        WB_BUSY           = 2'b01,
        WB_WAIT_FOR_STALL = 2'b11
    } wb_state_e;

    typedef struct packed {
        logic [RegBus-1:0] addr;
        logic [RegBus-1:0] data;
        logic              we;
        logic [3:0]        sel;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '{addr: ZeroWord, data: ZeroWord, we: 1'b0, sel: 4'b0000};

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts BUSY cycles; expired is high on the MAX_CYCLES-th one.
module wb_timeout_cnt #(
    parameter int MAX_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wishbone_bus_if.sv
// Wishbone B4 classic master bridge for one OpenMIPS memory port.
// Optional bus watchdog and bus_err_o port enabled by defining WB_TIMEOUT_EN.
module wishbone_bus_if
    import wishbone_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic [RegBus-1:0] cpu_data_i,
    input  logic [RegBus-1:0] cpu_addr_i,
    input  logic              cpu_we_i,
    input  logic [3:0]        cpu_sel_i,
    output logic [RegBus-1:0] cpu_data_o,
    output logic              stallreq,
    input  logic [RegBus-1:0] wishbone_data_i,
    input  logic              wishbone_ack_i,
    output logic [RegBus-1:0] wishbone_addr_o,
    output logic [RegBus-1:0] wishbone_data_o,
    output logic              wishbone_we_o,
    output logic [3:0]        wishbone_sel_o,
    output logic              wishbone_stb_o,
`ifdef WB_TIMEOUT_EN
    output logic              bus_err_o,
`endif
    output logic              wishbone_cyc_o
);

    wb_state_e         state, state_nxt;
    wb_req_t           req_q;
    logic              cyc_q;
    logic [RegBus-1:0] rd_buf;
    logic              start, ack_now, timeout_hit, is_read;

    assign start   = (cpu_ce_i == ChipEnable) && !flush_i;
    assign is_read = (cpu_we_i != WriteEnable);
    assign ack_now = (state == WB_BUSY) && wishbone_ack_i && !flush_i;

`ifdef WB_TIMEOUT_EN
    logic cnt_expired;

    wb_timeout_cnt #(.MAX_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    ((state == WB_IDLE) && start),
        .enable  (state == WB_BUSY),
        .expired (cnt_expired)
    );

    // An ack landing on the expiry cycle still completes the access normally.
    assign timeout_hit = (state == WB_BUSY) && cnt_expired && !wishbone_ack_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) bus_err_o <= 1'b0;
        else     bus_err_o <= timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        stallreq   = 1'b0;
        cpu_data_o = ZeroWord;
        case (state)
            WB_IDLE: begin
                stallreq = start;
                if (start) state_nxt = WB_BUSY;
            end
            WB_BUSY: begin
                if (flush_i) begin
                    state_nxt = WB_IDLE;
                end else if (ack_now || timeout_hit) begin
                    state_nxt = (stall_i != 6'd0) ? WB_WAIT_FOR_STALL : WB_IDLE;
                    if (ack_now && is_read) cpu_data_o = wishbone_data_i;
                end else begin
                    stallreq = 1'b1;
                end
            end
            WB_WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf;
                if (flush_i || stall_i == 6'd0) state_nxt = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    // stb and cyc share one flop so they can never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= WB_IDLE;
            req_q  <= WB_REQ_IDLE;
            cyc_q  <= 1'b0;
            rd_buf <= ZeroWord;
        end else begin
            state <= state_nxt;
            case (state)
                WB_IDLE: begin
                    if (start) begin
                        req_q  <= '{addr: cpu_addr_i, data: cpu_data_i, we: cpu_we_i, sel: cpu_sel_i};
                        cyc_q  <= 1'b1;
                        rd_buf <= ZeroWord;
                    end
                end
                WB_BUSY: begin
                    if (flush_i) begin
                        req_q  <= WB_REQ_IDLE;
                        cyc_q  <= 1'b0;
                        rd_buf <= ZeroWord;
                    end else if (ack_now || timeout_hit) begin
                        req_q <= WB_REQ_IDLE;
                        cyc_q <= 1'b0;
                        if (ack_now && is_read) rd_buf <= wishbone_data_i;
                    end
                end
                WB_WAIT_FOR_STALL: begin
                    if (flush_i) rd_buf <= ZeroWord;
                end
                default: ;
            endcase
        end
    end

    assign wishbone_addr_o = req_q.addr;
    assign wishbone_data_o = req_q.data;
    assign wishbone_we_o   = req_q.we;
    assign wishbone_sel_o  = req_q.sel;
    assign wishbone_stb_o  = cyc_q;
    assign wishbone_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Self-checking bench for wishbone_bus_if: vector table, hand-written corner
// sequences and randomized accesses checked against transaction-level expectations.
module tb_wishbone_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i, cpu_ce_i, cpu_we_i, wishbone_ack_i;
    logic [31:0] cpu_data_i, cpu_addr_i, wishbone_data_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o, wishbone_addr_o, wishbone_data_o;
    logic        stallreq, wishbone_we_o, wishbone_stb_o, wishbone_cyc_o;
    logic [3:0]  wishbone_sel_o;
`ifdef WB_TIMEOUT_EN
    logic        bus_err_o;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wishbone_bus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_data_i(cpu_data_i), .cpu_addr_i(cpu_addr_i),
        .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
        .stallreq(stallreq), .wishbone_data_i(wishbone_data_i),
        .wishbone_ack_i(wishbone_ack_i), .wishbone_addr_o(wishbone_addr_o),
        .wishbone_data_o(wishbone_data_o), .wishbone_we_o(wishbone_we_o),
        .wishbone_sel_o(wishbone_sel_o), .wishbone_stb_o(wishbone_stb_o),
`ifdef WB_TIMEOUT_EN
        .bus_err_o(bus_err_o),
`endif
        .wishbone_cyc_o(wishbone_cyc_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int          k;  // ack arrives k cycles after stb rises
        int          m;  // extra stalled cycles after the ack
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access; expectations follow from the timing rules directly.
    task automatic run_txn(input vec_t v);
        int          sr;
        logic [31:0] exp_rd;
        sr     = 0;
        exp_rd = v.we ? 32'h0 : v.rdata;
        cpu_ce_i = 1'b1; cpu_we_i = v.we; cpu_addr_i = v.addr; cpu_data_i = v.data;
        cpu_sel_i = v.sel; stall_i = 6'd0; wishbone_ack_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        sr += int'(stallreq);
        chk("req_data", cpu_data_o, 32'h0);
        step();
        for (int i = 0; i <= v.k; i++) begin
            if (i == v.k) begin
                wishbone_ack_i = 1'b1; wishbone_data_i = v.rdata;
                stall_i = (v.m > 0) ? 6'b001111 : 6'd0;
            end
            @(negedge clk);
            chk("stb_cyc", {wishbone_stb_o, wishbone_cyc_o}, 2'b11);
            chk("bus_hold", {wishbone_addr_o, wishbone_data_o, wishbone_sel_o, wishbone_we_o},
                {v.addr, v.data, v.sel, v.we});
            if (i < v.k) begin
                sr += int'(stallreq);
                chk("busy_data", cpu_data_o, 32'h0);
            end else begin
                chk("ack_stallreq", stallreq, 1'b0);
                chk("ack_data", cpu_data_o, exp_rd);
            end
            step();
        end
        chk("stallreq_len", sr, v.k + 1);
        wishbone_ack_i = 1'b0; wishbone_data_i = $urandom;
        for (int j = 0; j < v.m; j++) begin
            @(negedge clk);
            chk("wfs_data", cpu_data_o, exp_rd);
            chk("wfs_stallreq", stallreq, 1'b0);
            chk("wfs_stb", {wishbone_stb_o, wishbone_cyc_o}, 2'b00);
            step();
        end
        if (v.m > 0) begin
            stall_i = 6'd0;
            @(negedge clk);
            chk("wfs_release_data", cpu_data_o, exp_rd);
            step();
        end
        cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("idle_stb", {wishbone_stb_o, wishbone_cyc_o, wishbone_addr_o}, 34'h0);
        chk("idle_out", {stallreq, cpu_data_o}, 33'h0);
        step();
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{we: 1'b0, addr: 32'h10, data: 32'h0,         sel: 4'hF, rdata: 32'hDEAD_BEEF, k: 2, m: 0};
        tbl[1] = '{we: 1'b1, addr: 32'h20, data: 32'h1234_5678, sel: 4'b0011, rdata: 32'hFFFF_FFFF, k: 1, m: 0};
        tbl[2] = '{we: 1'b0, addr: 32'h30, data: 32'h0,         sel: 4'hF, rdata: 32'hA5A5_0001, k: 0, m: 3};
        tbl[3] = '{we: 1'b1, addr: 32'h40, data: 32'hCAFE_0000, sel: 4'hC, rdata: 32'h7777_7777, k: 0, m: 2};
        tbl[4] = '{we: 1'b0, addr: 32'h44, data: 32'h5555_AAAA, sel: 4'h1, rdata: 32'h0BAD_F00D, k: 4, m: 1};

        rst = 1'b1; stall_i = 6'd0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
        cpu_data_i = 32'h0; cpu_addr_i = 32'h0; cpu_sel_i = 4'h0;
        wishbone_data_i = 32'h0; wishbone_ack_i = 1'b0;
        step(); step();
        @(negedge clk);
        chk("reset_bus", {wishbone_addr_o, wishbone_data_o, wishbone_sel_o, wishbone_we_o,
                          wishbone_stb_o, wishbone_cyc_o}, 70'h0);
        chk("reset_out", {stallreq, cpu_data_o}, 33'h0);
`ifdef WB_TIMEOUT_EN
        chk("reset_err", bus_err_o, 1'b0);
`endif
        step();
        rst = 1'b0;

        // Ack while idle must be ignored.
        wishbone_ack_i = 1'b1; wishbone_data_i = 32'h1357_9BDF;
        @(negedge clk);
        chk("idle_ack_out", {stallreq, cpu_data_o}, 33'h0);
        step();
        wishbone_ack_i = 1'b0;
        @(negedge clk);
        chk("idle_ack_stb", {wishbone_stb_o, wishbone_cyc_o}, 2'b00);
        step();

        for (int t = 0; t < 5; t++) run_txn(tbl[t]);

        // Flush coinciding with ack: data dropped, bus released, no wait state.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h50; cpu_sel_i = 4'hF;
        step();
        flush_i = 1'b1; wishbone_ack_i = 1'b1; wishbone_data_i = 32'hBAD0_BAD0; stall_i = 6'h3F;
        @(negedge clk);
        chk("flush_ack_data", cpu_data_o, 32'h0);
        step();
        flush_i = 1'b0; wishbone_ack_i = 1'b0; cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("flush_bus", {wishbone_stb_o, wishbone_cyc_o, wishbone_addr_o}, 34'h0);
        chk("flush_idle_out", {stallreq, cpu_data_o}, 33'h0);
        step();
        stall_i = 6'd0;

        // Flush while waiting for the pipeline drops the buffered data.
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h60;
        step();
        wishbone_ack_i = 1'b1; wishbone_data_i = 32'h1111_2222; stall_i = 6'h3F;
        step();
        wishbone_ack_i = 1'b0;
        @(negedge clk);
        chk("wfs_buf", cpu_data_o, 32'h1111_2222);
        step();
        flush_i = 1'b1; cpu_ce_i = 1'b0;
        step();
        flush_i = 1'b0;
        @(negedge clk);
        chk("wfs_flush_data", {stallreq, cpu_data_o}, 33'h0);
        step();
        stall_i = 6'd0;

        // Reset mid-cycle aborts the bus cycle; a late ack is ignored.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h70; cpu_data_i = 32'h89AB_CDEF;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; cpu_ce_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_bus", {wishbone_addr_o, wishbone_data_o, wishbone_sel_o, wishbone_we_o,
                            wishbone_stb_o, wishbone_cyc_o}, 70'h0);
        step();
        wishbone_ack_i = 1'b1; wishbone_data_i = 32'h2468_ACE0;
        @(negedge clk);
        chk("rst_late_ack", {stallreq, cpu_data_o}, 33'h0);
        step();
        wishbone_ack_i = 1'b0;
        @(negedge clk);
        chk("rst_late_stb", wishbone_stb_o, 1'b0);
        step();

        // Back-to-back requests: stb must drop for one idle cycle.
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80;
        step();
        wishbone_ack_i = 1'b1; wishbone_data_i = 32'h0000_0080;
        step();
        wishbone_ack_i = 1'b0;
        @(negedge clk);
        chk("b2b_gap", {wishbone_stb_o, stallreq}, 2'b01);
        step();
        @(negedge clk);
        chk("b2b_restart", {wishbone_stb_o, wishbone_cyc_o}, 2'b11);
        step();
        wishbone_ack_i = 1'b1; cpu_ce_i = 1'b0;
        step();
        wishbone_ack_i = 1'b0;
        step();

`ifdef WB_TIMEOUT_EN
        begin
            int sr;
            sr = 0;
            cpu_ce_i = 1'b1; cpu_addr_i = 32'h90; stall_i = 6'd0;
            @(negedge clk); sr += int'(stallreq);
            step();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); sr += int'(stallreq);
                step();
            end
            @(negedge clk);
            chk("tmo_len", sr, 4);
            chk("tmo_out", {stallreq, cpu_data_o}, 33'h0);
            step();
            cpu_ce_i = 1'b0;
            @(negedge clk);
            chk("tmo_err", {bus_err_o, wishbone_stb_o, wishbone_cyc_o}, 3'b100);
            step();
            @(negedge clk);
            chk("tmo_err_pulse", bus_err_o, 1'b0);
            step();
        end
`endif

        for (int r = 0; r < 30; r++) begin
            vec_t v;
            v.we    = 1'($urandom_range(0, 1));
            v.addr  = $urandom & 32'hFFFF_FFFC;
            v.data  = $urandom;
            v.sel   = 4'($urandom_range(1, 15));
            v.rdata = $urandom;
            v.k     = $urandom_range(0, 4);
            v.m     = $urandom_range(0, 3);
            run_txn(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
